hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

Pipeline hazard controller for the 5-stage MIPS core. Sequences pipeline-register enables and bubble insertion for load-use stalls, taken-branch flushes and data-memory wait states. Its `ctrl_zero` output drives the main decoder's control-zeroing input, which forces a bubble into ID/EX. It sits beside the ID stage and observes ID, ID/EX and MEM status.

## Interface
Parameters:
- `BRANCH_PENALTY`, default 1: number of cycles IF/ID is flushed after a taken branch (1..7).
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_rs`, `id_rt`  in  5  each  source registers of the instruction in ID.
- `id_uses_rt`  in  1  instruction in ID reads rt (R-type, beq, sw).
- `ex_mem_read`  in  1  ID/EX MemRead (lw in EX).
- `ex_rt`  in  5  ID/EX rt (load destination).
- `branch_taken`  in  1  beq resolved taken in EX.
- `dmem_req`  in  1  MEM stage access in progress.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC update enable.
- `ifid_write`  out  1  IF/ID load enable.
- `ctrl_zero`  out  1  zero the decoder controls (bubble into ID/EX).
- `ifid_flush`  out  1  clear IF/ID to nop.
- `pipe_freeze`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  statistics counters; present only when the statistics macro is defined.

## Operation
States: RUN, FLUSH, MEM_WAIT. State is registered; outputs are a Mealy function of state and inputs.

- Hazard priority: mem wait > branch > load-use.
- **Mem wait:** `dmem_req & !dmem_ready` is evaluated in any state. It sets `pipe_freeze=1`, `pc_write=0` and `ifid_write=0`, with no flush and no bubble. Next state is MEM_WAIT; any FLUSH countdown is saved and resumes afterwards. MEM_WAIT is left in the cycle `dmem_ready=1`, returning to the saved state (RUN, or FLUSH with its remaining count).
- **Branch (RUN):** `branch_taken=1` sets `ifid_flush=1` and `ctrl_zero=1`, with `pc_write=1` to load the target.
  - `BRANCH_PENALTY>1`: go to FLUSH with `cnt=BRANCH_PENALTY-1`.
  - `BRANCH_PENALTY=1`: stay in RUN.
  - Any load-use hazard in the same cycle is ignored, because the ID instruction is wrong-path.
- **FLUSH:** `ifid_flush=1` and `ctrl_zero=1` every cycle while `cnt` decrements. Return to RUN after the cycle in which `cnt` reaches 1. `branch_taken` is ignored in FLUSH.
- **Load-use (RUN only):** `luh = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))`. When set: `pc_write=0`, `ifid_write=0`, `ctrl_zero=1`, and state stays RUN. The stall lasts exactly one cycle because the bubble clears `ex_mem_read` on the next cycle.
- Register `$0` never causes a hazard.
- Default in RUN with no hazard: `pc_write=1`, `ifid_write=1`, all other outputs 0.

## Timing
- Reset (asynchronous, takes effect immediately): state=RUN, `cnt=0`, counters=0.
- While `rst=1` the outputs are `pc_write=0`, `ifid_write=0`, `ctrl_zero=1`, `ifid_flush=0`, `pipe_freeze=0`. After reset release they follow RUN defaults in the same cycle.
- Reset in the middle of FLUSH or MEM_WAIT aborts it with no pending work retained.
- Latency: hazard outputs respond combinationally in the detection cycle; the state change takes effect at the next edge.
- `branch_taken` is qualified by `!pipe_freeze`. A branch held in EX during MEM_WAIT is acted on in the first unfrozen cycle.
- `dmem_ready` arriving without `dmem_req` is ignored.

## Configuration
- `HAZARD_STATS_EN`:
  - Defined: `stall_cnt` increments on every load-use or MEM_WAIT cycle. `flush_cnt` increments on every cycle with `ifid_flush=1`. Both saturate at all-ones.
  - Undefined: both counter ports and their logic are absent.

## Structure
- `hazard_pkg`: state encoding (RUN=2'd0, FLUSH=2'd1, MEM_WAIT=2'd2), opcode constants (R=0, lw=35, sw=43, beq=4), and the `REG_ZERO` constant.
- One sub-module, `load_use_detect`: the combinational `luh` comparator.

## Test plan
- `ex_mem_read=1`, `ex_rt=5`, `id_rs=5` in RUN -> one cycle with `pc_write=0`, `ifid_write=0`, `ctrl_zero=1`, then RUN defaults.
- `ex_rt=0`, `id_rs=0`, `ex_mem_read=1` -> no stall.
- `BRANCH_PENALTY=3`, `branch_taken` pulse -> `ifid_flush=1` for exactly 3 cycles, then `flush_cnt=3`.
- `branch_taken` and load-use hazard in the same cycle -> flush only, `pc_write=1`, no stall.
- `dmem_req=1` with `dmem_ready` low for 4 cycles during FLUSH `cnt=2` -> `pipe_freeze=1` for 4 cycles, then the flush resumes for its remaining 2 cycles.
- `rst` asserted mid-FLUSH -> immediately `ctrl_zero=1`, `pc_write=0`; after release, state RUN with counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding,
// MIPS opcode constants and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_BEQ = 6'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an instruction in ID that reads the destination
// of a load currently in EX. Register $0 never produces a hazard.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       luh
);

    logic rs_match;
    logic rt_match;

    // Source-operand match against the load destination.
    always_comb begin
        rs_match = (ex_rt == id_rs);
        rt_match = id_uses_rt && (ex_rt == id_rt);
        luh      = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer for the 5-stage MIPS core.
// Drives PC / IF/ID enables, IF/ID flush, decoder control-zeroing and the
// back-end freeze for load-use stalls, taken-branch flushes and dmem waits.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; branch and load-use hazards handled here
// FLUSH    | remaining wrong-path slots being flushed after a branch
// MEM_WAIT | data memory stalled; ret_state/cnt hold the work to resume
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ctrl_zero,
    output logic             ifid_flush,
    output logic             pipe_freeze
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(BRANCH_PENALTY - 1);

    hz_state_t               state, state_nxt;
    hz_state_t               ret_state, ret_state_nxt;
    hz_state_t               eff_state;
    logic [FLUSH_CNT_W-1:0]  cnt, cnt_nxt;
    logic                    luh;
    logic                    mem_wait;
    logic                    ld_stall;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .luh         (luh)
    );

    // State, resume state and flush countdown registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ret_state <= RUN;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_state_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // Next-state and Mealy outputs. The cycle in which a memory wait
    // completes behaves as a cycle of the saved state, so a paused flush
    // continues and a branch held in EX is taken in the first unfrozen cycle.
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ctrl_zero     = 1'b0;
        ifid_flush    = 1'b0;
        pipe_freeze   = 1'b0;
        ld_stall      = 1'b0;
        mem_wait      = dmem_req && !dmem_ready;
        eff_state     = (state == MEM_WAIT) ? ret_state : state;
        state_nxt     = eff_state;
        ret_state_nxt = ret_state;
        cnt_nxt       = cnt;

        if (mem_wait) begin
            // Highest priority: freeze everything, leave cnt untouched so a
            // flush in progress resumes where it stopped. branch_taken is
            // not looked at here, which is its qualification by freeze.
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            state_nxt   = MEM_WAIT;
            if (state != MEM_WAIT) begin
                ret_state_nxt = state;
            end
        end else begin
            case (eff_state)
                RUN: begin
                    if (branch_taken) begin
                        // ID holds a wrong-path instruction, so any load-use
                        // match this cycle is irrelevant.
                        ifid_flush = 1'b1;
                        ctrl_zero  = 1'b1;
                        if (BRANCH_PENALTY > 1) begin
                            state_nxt = FLUSH;
                            cnt_nxt   = FLUSH_LOAD;
                        end
                    end else if (luh) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        ctrl_zero  = 1'b1;
                        ld_stall   = 1'b1;
                    end
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    ctrl_zero  = 1'b1;
                    if (cnt <= FLUSH_CNT_W'(1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // While reset is held the front end is stopped and a bubble is forced.
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ctrl_zero   = 1'b1;
            ifid_flush  = 1'b0;
            pipe_freeze = 1'b0;
            ld_stall    = 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating stall and flush statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((ld_stall || pipe_freeze) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed scoreboard bench for hazard_sequencer with BRANCH_PENALTY=3.
// Output vector order: {pc_write, ifid_write, ctrl_zero, ifid_flush, pipe_freeze}.
module tb_hazard_sequencer;

    localparam int CNT_W = 16;

    localparam logic [4:0] O_RUN = 5'b11000;
    localparam logic [4:0] O_LU  = 5'b00100;
    localparam logic [4:0] O_FL  = 5'b11110;
    localparam logic [4:0] O_MW  = 5'b00001;
    localparam logic [4:0] O_RST = 5'b00100;

    typedef struct {
        string      name;
        logic [4:0] outs;
        int         sc;
        int         fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, branch_taken, dmem_req, dmem_ready;
    logic       pc_write, ifid_write, ctrl_zero, ifid_flush, pipe_freeze;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    hazard_sequencer #(.BRANCH_PENALTY(3), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ctrl_zero    (ctrl_zero),
        .ifid_flush   (ifid_flush),
        .pipe_freeze  (pipe_freeze)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Apply one input vector just after a rising edge and queue its expectation.
    task automatic step(input string name, input logic r,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] ert, input logic bt,
                        input logic dreq, input logic drdy, input logic [4:0] exp_o,
                        input int exp_sc = -1, input int exp_fc = -1);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        ex_mem_read  = mr;
        ex_rt        = ert;
        branch_taken = bt;
        dmem_req     = dreq;
        dmem_ready   = drdy;
        e.name = name;
        e.outs = exp_o;
        e.sc   = exp_sc;
        e.fc   = exp_fc;
        sb.push_back(e);
    endtask

    // Monitor: every falling edge presents one settled output vector.
    initial begin
        exp_t       e;
        logic [4:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {pc_write, ifid_write, ctrl_zero, ifid_flush, pipe_freeze};
                checks++;
                if (got !== e.outs) begin
                    errors++;
                    $display("FAIL %s: outputs got %b expected %b", e.name, got, e.outs);
                end
`ifdef HAZARD_STATS_EN
                if (e.sc >= 0) begin
                    checks++;
                    if (int'(stall_cnt) != e.sc) begin
                        errors++;
                        $display("FAIL %s_stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.sc);
                    end
                end
                if (e.fc >= 0) begin
                    checks++;
                    if (int'(flush_cnt) != e.fc) begin
                        errors++;
                        $display("FAIL %s_flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.fc);
                    end
                end
`endif
            end
        end
    end

    initial begin
        rst = 1'b1;
        {id_rs, id_rt, ex_rt} = '0;
        {id_uses_rt, ex_mem_read, branch_taken, dmem_req, dmem_ready} = '0;

        //     name             rst rs    rt    urt  mr  ert   bt  dreq drdy exp    sc  fc
        step("reset_hold",      1, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   0,   O_RST, 0,  0);
        step("run_default",     0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   0,   O_RUN);
        step("lu_rs",           0, 5'd5, 5'd0, 0,   1,  5'd5, 0,  0,   0,   O_LU);
        step("lu_bubble",       0, 5'd5, 5'd0, 0,   0,  5'd5, 0,  0,   0,   O_RUN, 1);
        step("lu_rt",           0, 5'd1, 5'd7, 1,   1,  5'd7, 0,  0,   0,   O_LU);
        step("rt_not_used",     0, 5'd1, 5'd7, 0,   1,  5'd7, 0,  0,   0,   O_RUN);
        step("reg_zero",        0, 5'd0, 5'd0, 1,   1,  5'd0, 0,  0,   0,   O_RUN);
        step("no_mem_read",     0, 5'd5, 5'd5, 1,   0,  5'd5, 0,  0,   0,   O_RUN);
        step("br_over_lu",      0, 5'd5, 5'd0, 0,   1,  5'd5, 1,  0,   0,   O_FL,  2,  0);
        step("flush_cnt2",      0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   0,   O_FL,  2,  1);
        step("flush_ign_br",    0, 5'd0, 5'd0, 0,   0,  5'd0, 1,  0,   0,   O_FL,  2,  2);
        step("flush_done",      0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   0,   O_RUN, 2,  3);
        step("br_again",        0, 5'd0, 5'd0, 0,   0,  5'd0, 1,  0,   0,   O_FL);
        step("mw_1",            0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  1,   0,   O_MW,  2,  4);
        step("mw_2",            0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  1,   0,   O_MW);
        step("mw_3",            0, 5'd0, 5'd0, 0,   0,  5'd0, 1,  1,   0,   O_MW);
        step("mw_4",            0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  1,   0,   O_MW);
        step("mw_ready",        0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  1,   1,   O_FL,  6,  4);
        step("flush_resume",    0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   0,   O_FL);
        step("resume_done",     0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   0,   O_RUN, 6,  6);
        step("mw_hold_br",      0, 5'd0, 5'd0, 0,   0,  5'd0, 1,  1,   0,   O_MW);
        step("br_unfrozen",     0, 5'd0, 5'd0, 0,   0,  5'd0, 1,  1,   1,   O_FL);
        step("flush_pre_rst",   0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   0,   O_FL);
        step("rst_mid_flush",   1, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   0,   O_RST, 0,  0);
        step("after_rst",       0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   0,   O_RUN, 0,  0);
        step("ready_no_req",    0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   1,   O_RUN);
        step("mw_over_lu",      0, 5'd5, 5'd0, 0,   1,  5'd5, 0,  1,   0,   O_MW);
        step("mw_end_run",      0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  1,   1,   O_RUN, 1,  0);
        step("idle_end",        0, 5'd0, 5'd0, 0,   0,  5'd0, 0,  0,   0,   O_RUN, 1,  0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
